// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch command sequencer: FSM states, command and source indices.
// Also holds the fixed-priority picker used inside a source (run > clr > tmp).
package stopwatch_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    localparam int CMD_RUN = 0;
    localparam int CMD_CLR = 1;
    localparam int CMD_TMP = 2;
    localparam int CMD_N   = 3;

    localparam logic SRC_BTN = 1'b0;
    localparam logic SRC_CPU = 1'b1;

    typedef logic [CMD_N-1:0] cmd_vec_t;

    // One-hot of the highest-priority pending command, or zero.
    function automatic cmd_vec_t pick_first(input cmd_vec_t pend);
        cmd_vec_t sel;
        sel = '0;
        if (pend[CMD_RUN]) begin
            sel[CMD_RUN] = 1'b1;
        end else if (pend[CMD_CLR]) begin
            sel[CMD_CLR] = 1'b1;
        end else if (pend[CMD_TMP]) begin
            sel[CMD_TMP] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/stopwatch_debounce.sv
// Button conditioner: 2-FF synchroniser, DBN-sample debounce, registered rising-edge pulse.
// Latency raw->rise is DBN+2 cycles; no backpressure (free-running per-cycle pipeline).
module stopwatch_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DBN = 4,
    parameter int DBL = $clog2(DBN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [DBL-1:0] DBN_L = DBL'(DBN);

    logic           sync1_q, sync2_q;
    logic           lvl_q, lvl_d;
    logic           rise_q, rise_d;
    logic [DBL-1:0] cnt_q, cnt_d, cnt_inc;

    // Counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        cnt_inc = cnt_q + DBL'(1);
        lvl_d   = lvl_q;
        cnt_d   = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_inc == DBN_L) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        rise_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer: debounced buttons + Avalon CPU writes -> spaced one-hot pulses on b_run/b_clr/b_tmp.
// Latency: button rise -> pulse in DBN+4 cycles, CPU write -> pulse 2 cycles later when idle; CPU held off via waitrequest while any CPU command is pending.
// Optional STOPWATCH_CTRL_LOCK_EN adds a CPU-writable lock (writedata[3]) that masks button commands.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DBN = 4,
    parameter int DBL = $clog2(DBN + 1),
    parameter int PLW = 2,
    parameter int GAP = 1,
    parameter int ADW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_run,
    input  logic           btn_clr,
    input  logic           btn_tmp,
    input  logic           avalon_write,
    input  logic [ADW-1:0] avalon_writedata,
    output logic           avalon_waitrequest,
    output logic           b_run,
    output logic           b_clr,
    output logic           b_tmp,
    output logic           busy
);

    localparam int CMAX = (PLW > GAP) ? PLW : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    cmd_vec_t btn_rise;
    cmd_vec_t btn_pend_q, btn_pend_d;
    cmd_vec_t cpu_pend_q, cpu_pend_d;
    cmd_vec_t drv_q, drv_d;
    cmd_vec_t gnt_vec, btn_gnt, cpu_gnt, wr_cmd;
    state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic     rr_q, rr_d;
    logic     gnt_src, take;
    logic     btn_any, cpu_any, wr_acc;

    stopwatch_debounce #(.DBN(DBN), .DBL(DBL)) u_dbn_run (
        .clk(clk), .rst(rst), .raw(btn_run), .rise(btn_rise[CMD_RUN])
    );
    stopwatch_debounce #(.DBN(DBN), .DBL(DBL)) u_dbn_clr (
        .clk(clk), .rst(rst), .raw(btn_clr), .rise(btn_rise[CMD_CLR])
    );
    stopwatch_debounce #(.DBN(DBN), .DBL(DBL)) u_dbn_tmp (
        .clk(clk), .rst(rst), .raw(btn_tmp), .rise(btn_rise[CMD_TMP])
    );

    assign avalon_waitrequest = |cpu_pend_q;
    assign wr_acc             = avalon_write & ~avalon_waitrequest;
    assign wr_cmd             = avalon_writedata[CMD_N-1:0];

`ifdef STOPWATCH_CTRL_LOCK_EN
    logic           lock_q, lock_d;
    logic [ADW-5:0] unused_wd;
    assign unused_wd = avalon_writedata[ADW-1:4];

    always_comb begin
        lock_d = lock_q;
        if (wr_acc) begin
            lock_d = avalon_writedata[3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic [ADW-4:0] unused_wd;
    assign unused_wd = avalon_writedata[ADW-1:3];
`endif

    // Round-robin between sources only matters when both have work.
    always_comb begin
        btn_any = |btn_pend_q;
        cpu_any = |cpu_pend_q;
        if (btn_any && cpu_any) begin
            gnt_src = rr_q;
        end else begin
            gnt_src = cpu_any ? SRC_CPU : SRC_BTN;
        end
        gnt_vec = pick_first((gnt_src == SRC_CPU) ? cpu_pend_q : btn_pend_q);
    end

    // A GAP expiry with work pending launches the next pulse directly, so back-to-back pulses are GAP apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        rr_d    = rr_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take = btn_any | cpu_any;
            end
            ST_DRIVE: begin
                if (cnt_q == CW'(PLW - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    drv_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    take    = btn_any | cpu_any;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                drv_d   = '0;
            end
        endcase

        btn_gnt = '0;
        cpu_gnt = '0;
        if (take) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            drv_d   = gnt_vec;
            if (gnt_src == rr_q) begin
                rr_d = ~rr_q;
            end
            if (gnt_src == SRC_CPU) begin
                cpu_gnt = gnt_vec;
            end else begin
                btn_gnt = gnt_vec;
            end
        end
    end

    // New requests are OR-ed in after the grant clear, so a same-cycle set survives.
    always_comb begin
        btn_pend_d = (btn_pend_q & ~btn_gnt) | btn_rise;
`ifdef STOPWATCH_CTRL_LOCK_EN
        if (lock_q) begin
            btn_pend_d = '0;
        end
`endif
        cpu_pend_d = (cpu_pend_q & ~cpu_gnt) | (wr_acc ? wr_cmd : cmd_vec_t'(0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drv_q      <= '0;
            rr_q       <= SRC_BTN;
            btn_pend_q <= '0;
            cpu_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drv_q      <= drv_d;
            rr_q       <= rr_d;
            btn_pend_q <= btn_pend_d;
            cpu_pend_q <= cpu_pend_d;
        end
    end

    assign b_run = drv_q[CMD_RUN];
    assign b_clr = drv_q[CMD_CLR];
    assign b_tmp = drv_q[CMD_TMP];
    assign busy  = (state_q != ST_IDLE) | btn_any | cpu_any;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed timing checks plus randomized rounds against a queue-based ordering model.
module tb_stopwatch_ctrl;

    localparam int DBN = 4;
    localparam int PLW = 2;
    localparam int GAP = 1;
    localparam int ADW = 32;

    logic           clk;
    logic           rst;
    logic           btn_run, btn_clr, btn_tmp;
    logic           avalon_write;
    logic [ADW-1:0] avalon_writedata;
    logic           avalon_waitrequest;
    logic           b_run, b_clr, b_tmp;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int obs_q[$];
    int exp_q[$];
    int ptr_m = 0;

    stopwatch_ctrl #(.DBN(DBN), .PLW(PLW), .GAP(GAP), .ADW(ADW)) dut (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_clr(btn_clr), .btn_tmp(btn_tmp),
        .avalon_write(avalon_write), .avalon_writedata(avalon_writedata),
        .avalon_waitrequest(avalon_waitrequest),
        .b_run(b_run), .b_clr(b_clr), .b_tmp(b_tmp), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: shape checks and capture of issued command order.
    initial begin : mon
        logic [2:0] prev, cur;
        int wid, gap;
        prev = '0; wid = 0; gap = 1000;
        forever begin
            @(negedge clk);
            cur = {b_tmp, b_clr, b_run};
            if (!rst) begin
                prev = '0; wid = 0; gap = 1000;
            end else begin
                if (cur != 3'b000) check("onehot", int'($onehot(cur)), 1);
                if (prev == 3'b000 && cur != 3'b000) begin
                    check("gap", int'(gap >= GAP), 1);
                    obs_q.push_back(cur[0] ? 0 : (cur[1] ? 1 : 2));
                    wid = 1;
                end else if (cur != 3'b000) begin
                    wid++;
                end else if (prev != 3'b000) begin
                    check("width", wid, PLW);
                    gap = 1;
                end else begin
                    gap++;
                end
                prev = cur;
            end
        end
    end

    // Reference: all commands pending at once; sources alternate by pointer, priority run>clr>tmp inside a source.
    task automatic model_order(input logic [2:0] bm, input logic [2:0] cm);
        int bq[$];
        int cq[$];
        int src;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            if (bm[c]) bq.push_back(c);
            if (cm[c]) cq.push_back(c);
        end
        while (bq.size() > 0 || cq.size() > 0) begin
            if (bq.size() > 0 && cq.size() > 0) src = ptr_m;
            else src = (bq.size() > 0) ? 0 : 1;
            if (src == ptr_m) ptr_m = 1 - ptr_m;
            if (src == 0) exp_q.push_back(bq.pop_front());
            else exp_q.push_back(cq.pop_front());
        end
    endtask

    task automatic compare_order(input string tag);
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
    endtask

    task automatic cpu_write(input logic [ADW-1:0] d);
        int tries;
        tries = 0;
        avalon_write = 1'b1;
        avalon_writedata = d;
        while (avalon_waitrequest && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        check("wr_ready", int'(avalon_waitrequest), 0);
        @(negedge clk);
        avalon_write = 1'b0;
    endtask

    // Buttons in bm pressed at cycle 0; CPU write lands so both sources are pending together at cycle DBN+3.
    task automatic run_round(input logic [2:0] bm, input logic [2:0] cm, input logic do_wr, input int hold);
        int gst[3];
        int gln[3];
        logic [2:0] raw;
        logic [ADW-1:0] wd;
        wd = {$urandom(), 3'b000} | ADW'(cm);
`ifdef STOPWATCH_CTRL_LOCK_EN
        wd[3] = 1'b0;
`endif
        for (int c = 0; c < 3; c++) begin
            gst[c] = $urandom_range(0, 12);
            gln[c] = $urandom_range(1, DBN - 1);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            for (int c = 0; c < 3; c++)
                raw[c] = bm[c] ? (cyc < hold) : (cyc >= gst[c] && cyc < gst[c] + gln[c]);
            {btn_tmp, btn_clr, btn_run} = raw;
            if (cyc == DBN + 2 && do_wr) begin
                check("rnd_wr_ready", int'(avalon_waitrequest), 0);
                avalon_write = 1'b1;
                avalon_writedata = wd;
            end else begin
                avalon_write = 1'b0;
            end
            @(negedge clk);
        end
        check("rnd_idle", int'(busy), 0);
        model_order(bm, do_wr ? cm : 3'b000);
        compare_order("rnd_order");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin : main
        int start;
        logic [2:0] expv;
        rst = 1'b0;
        btn_run = 0; btn_clr = 0; btn_tmp = 0;
        avalon_write = 0; avalon_writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_outs", int'({b_tmp, b_clr, b_run}), 0);
        check("rst_wait", int'(avalon_waitrequest), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);

        // Clean run press: pulse in cycles DBN+4..DBN+4+PLW-1, busy from DBN+3 until end of GAP.
        btn_run = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 20) btn_run = 1'b0;
            check("t1_run", int'(b_run), int'(n >= DBN + 4 && n < DBN + 4 + PLW));
            check("t1_busy", int'(busy), int'(n >= DBN + 3 && n < DBN + 4 + PLW + GAP));
        end
        model_order(3'b001, 3'b000);
        compare_order("t1_order");

        // Short glitch must not register.
        btn_clr = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) btn_clr = 1'b0;
            check("glitch", int'({busy, b_clr}), 0);
        end

        // CPU write of all three commands: back-to-back pulses GAP apart, waitrequest until tmp granted.
        avalon_write = 1'b1;
        avalon_writedata = 32'h7;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) avalon_write = 1'b0;
            expv = 3'b000;
            for (int k = 0; k < 3; k++) begin
                start = 2 + k * (PLW + GAP);
                if (n >= start && n < start + PLW) expv[k] = 1'b1;
            end
            check("t4_pulse", int'({b_tmp, b_clr, b_run}), int'(expv));
            check("t4_wait", int'(avalon_waitrequest), int'(n >= 1 && n < 2 + 2 * (PLW + GAP)));
        end
        model_order(3'b000, 3'b111);
        compare_order("t4_order");

        // Same command from both sources, then a follow-up that exposes the pointer.
        run_round(3'b100, 3'b100, 1'b1, 15);
        run_round(3'b010, 3'b001, 1'b1, 15);

        // Reset during a clear pulse.
        avalon_write = 1'b1;
        avalon_writedata = 32'h2;
        @(negedge clk);
        avalon_write = 1'b0;
        @(negedge clk);
        check("rst_pre", int'(b_clr), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_drop", int'({b_tmp, b_clr, b_run}), 0);
        check("rst_drop_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        ptr_m = 0;
        repeat (20) @(negedge clk);
        check("rst_nopulse", obs_q.size(), 0);
        check("rst_idle", int'(busy), 0);

`ifdef STOPWATCH_CTRL_LOCK_EN
        cpu_write(32'h8);
        repeat (3) @(negedge clk);
        btn_run = 1'b1;
        repeat (12) @(negedge clk);
        btn_run = 1'b0;
        repeat (30) @(negedge clk);
        check("lock_block", obs_q.size(), 0);
        cpu_write(32'h0);
        repeat (3) @(negedge clk);
        btn_run = 1'b1;
        repeat (12) @(negedge clk);
        btn_run = 1'b0;
        repeat (30) @(negedge clk);
        model_order(3'b001, 3'b000);
        compare_order("unlock");
`endif

        for (int r = 0; r < 30; r++) begin
            run_round(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), $urandom_range(8, 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
